gf163_mul_seq: RTL and testbench

Digit-serial sequencer for the GF(2^163) multiplier datapath. It accepts two 163-bit field elements on a start/ready handshake and holds A and the reduction polynomial constant. B is consumed 16 bits per cycle, most-significant digit first. Each cycle the block applies the 16-row shift/reduce/accumulate step (the combinational PE step) to a registered partial product, and after 11 steps it presents A·B mod f(x) with a done pulse. It sits between the point-arithmetic control and the multiplier datapath.

---
 rtl/gf163_mul_seq.sv | 101 ++++++++++
 tb/tb_gf163_mul_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf163_mul_seq.sv
// Digit-serial GF(2^163) multiplier sequencer: consumes B sixteen bits per cycle,
// most-significant digit first, and presents A*B mod f(x) with a one-cycle done pulse.
module gf163_mul_seq #(
    parameter int             M      = 163,
    parameter int             D      = 16,
    parameter int             NDIG   = 11,
    parameter logic [M-1:0]   G_POLY = 'hC9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           clear,
    input  logic [M-1:0]   a_in,
    input  logic [M-1:0]   b_in,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [M-1:0]   result,
    output logic           result_valid
);

    localparam int         BW      = NDIG * D;
    localparam logic [3:0] CNT_TOP = 4'(NDIG - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [M-1:0]    a_reg;
    logic [BW-1:0]   b_reg;
    logic [M-1:0]    t_reg;

    logic [D-1:0]    digit;
    logic [M-1:0]    t_next;

    // One digit step: per row, multiply by x and fold the overflow back in with
    // the low part of f(x) before accumulating A, so t never reaches degree M.
    always_comb begin
        digit  = b_reg[cnt*D +: D];
        t_next = t_reg;
        for (int j = D - 1; j >= 0; j--) begin
            t_next = {t_next[M-2:0], 1'b0} ^ (t_next[M-1] ? G_POLY : '0);
            if (digit[j]) begin
                t_next = t_next ^ a_reg;
            end
        end
    end

    // Control and datapath registers; clear dominates both accept and stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            t_reg        <= '0;
            result       <= '0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state        <= IDLE;
                cnt          <= '0;
                result_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            a_reg        <= a_in;
                            b_reg        <= BW'(b_in);
                            t_reg        <= '0;
                            cnt          <= CNT_TOP;
                            result_valid <= 1'b0;
                            state        <= RUN;
                        end
                    end
                    RUN: begin
                        if (cnt != '0) begin
                            t_reg <= t_next;
                            cnt   <= cnt - 4'd1;
                        end else begin
                            result       <= t_next;
                            done         <= 1'b1;
                            result_valid <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);

endmodule

// File: tb/tb_gf163_mul_seq.sv
// Self-checking bench for gf163_mul_seq: directed and random products compared
// against a schoolbook carry-less multiply followed by polynomial long division.
module tb_gf163_mul_seq;

    localparam int M = 163;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           clear = 1'b0;
    logic [M-1:0]   a_in = '0;
    logic [M-1:0]   b_in = '0;
    logic           ready;
    logic           busy;
    logic           done;
    logic [M-1:0]   result;
    logic           result_valid;

    int checks = 0;
    int fails  = 0;

    gf163_mul_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .clear        (clear),
        .a_in         (a_in),
        .b_in         (b_in),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Full 325-bit carry-less product, then reduce by f(x) from the top bit down.
    function automatic logic [M-1:0] gfMul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] p;
        logic [M:0]     f;
        p = '0;
        f = '0;
        f[M] = 1'b1;
        f[7] = 1'b1;
        f[6] = 1'b1;
        f[3] = 1'b1;
        f[0] = 1'b1;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ ({{(M-1){1'b0}}, a} << i);
        end
        for (int k = 2*M-2; k >= M; k--) begin
            if (p[k]) p = p ^ ({{(M-2){1'b0}}, f} << (k - M));
        end
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] randElem();
        logic [191:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w[M-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done; counts cycles after the accept edge and busy samples.
    task automatic waitDone(output int lat, inout int busyCycles);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) busyCycles++;
        end
    endtask

    task automatic applyStimulus(input logic [M-1:0] a, input logic [M-1:0] b,
                                 output int lat, output int busyCycles);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        busyCycles = busy ? 1 : 0;
        waitDone(lat, busyCycles);
    endtask

    initial begin
        int           lat;
        int           bc;
        int           doneSeen;
        logic [M-1:0] a1, b1, a2, b2, exp;

        // Reset state
        #12;
        checkOutput("rst_ready", M'(ready), M'(1'b1));
        checkOutput("rst_busy", M'(busy), '0);
        checkOutput("rst_done", M'(done), '0);
        checkOutput("rst_result", result, '0);
        checkOutput("rst_valid", M'(result_valid), '0);
        rst_n = 1'b1;
        tick();

        // 1 * 1
        applyStimulus(M'(1), M'(1), lat, bc);
        checkOutput("one_latency", M'(lat), M'(11));
        checkOutput("one_result", result, M'(1));
        checkOutput("one_valid", M'(result_valid), M'(1'b1));
        checkOutput("one_ready", M'(ready), M'(1'b1));
        tick();
        checkOutput("one_done_pulse", M'(done), '0);

        // 2 * 3 and busy duration
        applyStimulus(M'(2), M'(3), lat, bc);
        checkOutput("small_result", result, M'(6));
        checkOutput("small_busy_cycles", M'(bc), M'(11));
        checkOutput("small_latency", M'(lat), M'(11));

        // Clear on the third step keeps the previous result
        a_in = randElem();
        b_in = randElem();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("accept_clears_valid", M'(result_valid), '0);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clr_busy", M'(busy), '0);
        checkOutput("clr_ready", M'(ready), M'(1'b1));
        checkOutput("clr_result", result, M'(6));
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) doneSeen++;
            tick();
        end
        checkOutput("clr_no_done", M'(doneSeen), '0);

        // Single reduction: x^162 * x
        a1 = '0;
        a1[162] = 1'b1;
        applyStimulus(a1, M'(2), lat, bc);
        checkOutput("reduce_result", result, M'(8'hC9));
        checkOutput("reduce_model", result, gfMul(a1, M'(2)));

        // x^100 * x^100 = x^44 + x^43 + x^40 + x^37
        a1 = '0;
        a1[100] = 1'b1;
        exp = '0;
        exp[44] = 1'b1;
        exp[43] = 1'b1;
        exp[40] = 1'b1;
        exp[37] = 1'b1;
        applyStimulus(a1, a1, lat, bc);
        checkOutput("wide_result", result, exp);

        // Start pulsed mid-run is ignored
        a1 = randElem();
        b1 = randElem();
        a_in = a1;
        b_in = b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        a_in = randElem();
        b_in = randElem();
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        waitDone(lat, bc);
        checkOutput("ignore_latency", M'(lat + 5), M'(11));
        checkOutput("ignore_result", result, gfMul(a1, b1));
        tick();
        tick();
        checkOutput("ignore_no_requeue", M'(busy), '0);

        // Start held high: back-to-back accept on the done cycle
        a1 = randElem();
        b1 = randElem();
        a2 = randElem();
        b2 = randElem();
        a_in = a1;
        b_in = b1;
        start = 1'b1;
        tick();
        a_in = a2;
        b_in = b2;
        waitDone(lat, bc);
        checkOutput("b2b_first_latency", M'(lat), M'(11));
        checkOutput("b2b_first_result", result, gfMul(a1, b1));
        tick();
        start = 1'b0;
        checkOutput("b2b_reaccept_busy", M'(busy), M'(1'b1));
        checkOutput("b2b_reaccept_valid", M'(result_valid), '0);
        waitDone(lat, bc);
        checkOutput("b2b_spacing", M'(lat + 1), M'(12));
        checkOutput("b2b_second_result", result, gfMul(a2, b2));
        tick();

        // clear and start together in IDLE: no accept
        exp = result;
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        checkOutput("clrstart_busy", M'(busy), '0);
        checkOutput("clrstart_valid", M'(result_valid), '0);
        checkOutput("clrstart_result", result, exp);

        // Random products
        for (int n = 0; n < 6; n++) begin
            a1 = randElem();
            b1 = randElem();
            applyStimulus(a1, b1, lat, bc);
            checkOutput($sformatf("rand%0d_result", n), result, gfMul(a1, b1));
            checkOutput($sformatf("rand%0d_latency", n), M'(lat), M'(11));
        end

        // Asynchronous reset mid-run
        applyStimulus(M'(5), M'(7), lat, bc);
        a_in = randElem();
        b_in = randElem();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", M'(busy), '0);
        checkOutput("arst_ready", M'(ready), M'(1'b1));
        checkOutput("arst_result", result, '0);
        checkOutput("arst_valid", M'(result_valid), '0);
        #10;
        rst_n = 1'b1;
        tick();
        applyStimulus(M'(1), M'(1), lat, bc);
        checkOutput("post_rst_latency", M'(lat), M'(11));
        checkOutput("post_rst_result", result, M'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
